// File: rtl/cast_arb_pkg.sv
// Shared types for the cast operation arbiter.
//   cast_opc_e : runtime cast opcode carried on every request
//   state_e    : result-register occupancy
//   CAST_OPC_W : opcode field width
package cast_arb_pkg;

   localparam int unsigned CAST_OPC_W = 2;

   typedef enum logic [CAST_OPC_W-1:0] {
      CAST_ZEXT  = 2'd0,
      CAST_SEXT  = 2'd1,
      CAST_TRUNC = 2'd2,
      CAST_NONE  = 2'd3
   } cast_opc_e;

   typedef enum logic {
      IDLE = 1'b0,
      FULL = 1'b1
   } state_e;

endpackage

// File: rtl/cast_op_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters, the arbiter and one consumer.
//   req_valid/req_ready/req_opcode/req_lhs : per-requester request handshake
//   rsp_valid/rsp_ready/rsp_id/rsp_ret/rsp_err : shared response handshake
// Modports:
//   master : requesters + consumer side (drives requests and rsp_ready)
//   slave  : arbiter side
interface cast_op_arbiter_if
   import cast_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned ParamBitWidth  = 32,
   parameter int unsigned ReturnBitWidth = 32
);

   localparam int unsigned IdW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]                    req_valid;
   logic [NUM_REQ-1:0]                    req_ready;
   logic [NUM_REQ-1:0][CAST_OPC_W-1:0]    req_opcode;
   logic [NUM_REQ-1:0][ParamBitWidth-1:0] req_lhs;
   logic                                  rsp_valid;
   logic                                  rsp_ready;
   logic [IdW-1:0]                        rsp_id;
   logic [ReturnBitWidth-1:0]             rsp_ret;
   logic                                  rsp_err;

   modport master (
      output req_valid, req_opcode, req_lhs, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_ret, rsp_err
   );

   modport slave (
      input  req_valid, req_opcode, req_lhs, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_ret, rsp_err
   );

endinterface

// File: rtl/cast_op_dyn.sv
// Purely combinational integer cast with a runtime opcode.
//   opcode : cast_opc_e selecting zext / sext / trunc / none
//   lhs    : ParamBitWidth operand
//   ret    : ReturnBitWidth result (0 for CAST_NONE)
//   err    : set for CAST_NONE
module cast_op_dyn
   import cast_arb_pkg::*;
#(
   parameter int unsigned ParamBitWidth  = 32,
   parameter int unsigned ReturnBitWidth = 32
) (
   input  cast_opc_e                 opcode,
   input  logic [ParamBitWidth-1:0]  lhs,
   output logic [ReturnBitWidth-1:0] ret,
   output logic                      err
);

   // Work at the wider of the two widths so every cast is a plain low-bit slice.
   localparam int unsigned W = (ParamBitWidth > ReturnBitWidth) ? ParamBitWidth : ReturnBitWidth;

   logic [W-1:0] zext_w;
   logic [W-1:0] sext_w;

   assign zext_w = W'(lhs);
   assign sext_w = W'($signed(lhs));

   always_comb begin
      ret = '0;
      err = 1'b0;
      unique case (opcode)
         CAST_ZEXT:  ret = zext_w[ReturnBitWidth-1:0];
         CAST_SEXT:  ret = sext_w[ReturnBitWidth-1:0];
         // Narrowing: low bits of sext equal low bits of lhs; widening: sign-extend.
         CAST_TRUNC: ret = sext_w[ReturnBitWidth-1:0];
         CAST_NONE:  err = 1'b1;
         default:    err = 1'b1;
      endcase
   end

endmodule

// File: rtl/cast_op_arbiter.sv
// Shares one runtime-configurable cast datapath between NUM_REQ requesters.
// One request is granted per cycle into a single result register, which is
// drained through the rsp_* handshake; a new result can load in the same
// cycle the old one is consumed.
//   clk     : clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : cast_op_arbiter_if.slave (requests in, registered response out)
// Build option: CAST_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// otherwise fixed priority with the lowest index winning.
module cast_op_arbiter
   import cast_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned ParamBitWidth  = 32,
   parameter int unsigned ReturnBitWidth = 32
) (
   input logic              clk,
   input logic              reset_n,
   cast_op_arbiter_if.slave bus
);

   localparam int unsigned IdW = $clog2(NUM_REQ);

   state_e                    state_q;
   logic [IdW-1:0]            id_q;
   logic [ReturnBitWidth-1:0] ret_q;
   logic                      err_q;

   logic [IdW-1:0]            cand;
   logic [IdW-1:0]            gnt_idx;
   logic                      gnt_found;
   logic                      slot_free;
   logic                      accept;
   logic [ReturnBitWidth-1:0] cast_ret;
   logic                      cast_err;

`ifdef CAST_ARB_ROUND_ROBIN_EN
   logic [IdW-1:0] ptr_q;
`endif

   // First valid requester in search order.
   always_comb begin
      cand      = '0;
      gnt_idx   = '0;
      gnt_found = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef CAST_ARB_ROUND_ROBIN_EN
         cand = IdW'((32'(ptr_q) + i) % NUM_REQ);
`else
         cand = IdW'(i);
`endif
         if (!gnt_found && bus.req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   assign slot_free = (state_q == IDLE) || bus.rsp_ready;
   assign accept    = reset_n && slot_free && gnt_found;

   always_comb begin
      bus.req_ready = '0;
      if (accept) bus.req_ready[gnt_idx] = 1'b1;
   end

   cast_op_dyn #(
      .ParamBitWidth  (ParamBitWidth),
      .ReturnBitWidth (ReturnBitWidth)
   ) u_cast (
      .opcode (cast_opc_e'(bus.req_opcode[gnt_idx])),
      .lhs    (bus.req_lhs[gnt_idx]),
      .ret    (cast_ret),
      .err    (cast_err)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         id_q    <= '0;
         ret_q   <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         state_q <= FULL;
         id_q    <= gnt_idx;
         ret_q   <= cast_ret;
         err_q   <= cast_err;
      end else if (bus.rsp_ready) begin
         state_q <= IDLE;
      end
   end

`ifdef CAST_ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ptr_q <= '0;
      end else if (accept) begin
         ptr_q <= (gnt_idx == IdW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end
`endif

   assign bus.rsp_valid = (state_q == FULL);
   assign bus.rsp_id    = id_q;
   assign bus.rsp_ret   = ret_q;
   assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_cast_op_arbiter.sv
module tb_cast_op_arbiter;
   import cast_arb_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   cast_op_arbiter_if #(.NUM_REQ(4), .ParamBitWidth(32), .ReturnBitWidth(32)) bus ();
   cast_op_arbiter_if #(.NUM_REQ(2), .ParamBitWidth(8),  .ReturnBitWidth(16)) bus1 ();
   cast_op_arbiter_if #(.NUM_REQ(2), .ParamBitWidth(16), .ReturnBitWidth(8))  bus2 ();

   cast_op_arbiter #(.NUM_REQ(4), .ParamBitWidth(32), .ReturnBitWidth(32)) dut (
      .clk (clk), .reset_n (reset_n), .bus (bus.slave));
   cast_op_arbiter #(.NUM_REQ(2), .ParamBitWidth(8), .ReturnBitWidth(16)) dut_w1 (
      .clk (clk), .reset_n (reset_n), .bus (bus1.slave));
   cast_op_arbiter #(.NUM_REQ(2), .ParamBitWidth(16), .ReturnBitWidth(8)) dut_w2 (
      .clk (clk), .reset_n (reset_n), .bus (bus2.slave));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Requester protocol: a pending (valid, not ready) request must not drop.
   logic [3:0] pend_q = '0;
   always @(posedge clk) begin
      if (reset_n && ((pend_q & ~bus.req_valid) != 4'b0)) begin
         errors++;
         checks++;
         $display("FAIL req_valid_dropped: pending %b valid %b", pend_q, bus.req_valid);
      end
      pend_q <= reset_n ? (bus.req_valid & ~bus.req_ready) : 4'b0;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int unsigned idx;
      logic [1:0]  opc;
      logic [31:0] lhs;
      logic [31:0] ret;
      logic        err;
   } vec_t;

   vec_t vecs[5];
   logic [3:0] exp_rdy[5];
   logic [1:0] exp_id[5];

   initial begin
      vecs[0] = '{2, CAST_SEXT,  32'h8000_0001, 32'h8000_0001, 1'b0};
      vecs[1] = '{1, CAST_ZEXT,  32'h0000_00FF, 32'h0000_00FF, 1'b0};
      vecs[2] = '{3, CAST_TRUNC, 32'hFFFF_0000, 32'hFFFF_0000, 1'b0};
      vecs[3] = '{0, CAST_NONE,  32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
      vecs[4] = '{2, CAST_ZEXT,  32'h1234_5678, 32'h1234_5678, 1'b0};
`ifdef CAST_ARB_ROUND_ROBIN_EN
      exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
      exp_rdy = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
      exp_id  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif

      bus.req_valid = '0;  bus.req_opcode = '0;  bus.req_lhs = '0;  bus.rsp_ready = 1'b1;
      bus1.req_valid = '0; bus1.req_opcode = '0; bus1.req_lhs = '0; bus1.rsp_ready = 1'b1;
      bus2.req_valid = '0; bus2.req_opcode = '0; bus2.req_lhs = '0; bus2.rsp_ready = 1'b1;

      // Reset state
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("reset_rsp_ret", bus.rsp_ret, 32'd0);
      chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
      reset_n = 1'b1;

      // Single-request vectors, back to back with rsp_ready=1
      for (int v = 0; v < 5; v++) begin
         bus.req_valid = '0;
         bus.req_valid[vecs[v].idx]  = 1'b1;
         bus.req_opcode[vecs[v].idx] = vecs[v].opc;
         bus.req_lhs[vecs[v].idx]    = vecs[v].lhs;
         #1;
         chk($sformatf("vec%0d_req_ready", v), 32'(bus.req_ready), 32'(4'b1 << vecs[v].idx));
         @(posedge clk); #1;
         chk($sformatf("vec%0d_rsp_valid", v), 32'(bus.rsp_valid), 32'd1);
         chk($sformatf("vec%0d_rsp_id", v), 32'(bus.rsp_id), vecs[v].idx);
         chk($sformatf("vec%0d_rsp_ret", v), bus.rsp_ret, vecs[v].ret);
         chk($sformatf("vec%0d_rsp_err", v), 32'(bus.rsp_err), 32'(vecs[v].err));
      end
      bus.req_valid = '0;
      @(posedge clk); #1;
      chk("drain_rsp_valid", 32'(bus.rsp_valid), 32'd0);

      // Width rules on the narrow/wide instances
      bus1.req_valid = 2'b01; bus1.req_opcode[0] = CAST_ZEXT;  bus1.req_lhs[0] = 8'hF0;
      bus2.req_valid = 2'b01; bus2.req_opcode[0] = CAST_TRUNC; bus2.req_lhs[0] = 16'h1234;
      @(posedge clk); #1;
      chk("w8to16_zext", 32'(bus1.rsp_ret), 32'h0000_00F0);
      chk("w16to8_trunc", 32'(bus2.rsp_ret), 32'h0000_0034);
      bus1.req_opcode[0] = CAST_SEXT;
      bus2.req_opcode[0] = CAST_SEXT; bus2.req_lhs[0] = 16'h00F0;
      @(posedge clk); #1;
      chk("w8to16_sext", 32'(bus1.rsp_ret), 32'h0000_FFF0);
      chk("w16to8_sext", 32'(bus2.rsp_ret), 32'h0000_00F0);
      bus1.req_valid = '0; bus2.req_valid = '0;

      // All requesters valid continuously, arbitration order
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      bus.req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         bus.req_opcode[i] = CAST_ZEXT;
         bus.req_lhs[i]    = 32'(i);
      end
      #1;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("arb%0d_req_ready", k), 32'(bus.req_ready), 32'(exp_rdy[k]));
         @(posedge clk); #1;
         chk($sformatf("arb%0d_rsp_id", k), 32'(bus.rsp_id), 32'(exp_id[k]));
         chk($sformatf("arb%0d_rsp_ret", k), bus.rsp_ret, 32'(exp_id[k]));
      end
      reset_n = 1'b0;
      bus.req_valid = '0;
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Backpressure: hold FULL for 3 cycles, then no-bubble handover
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'b0001; bus.req_opcode[0] = CAST_ZEXT; bus.req_lhs[0] = 32'h11;
      #1;
      chk("bp_first_ready", 32'(bus.req_ready), 32'b0001);
      @(posedge clk); #1;
      bus.req_valid = 4'b0010; bus.req_opcode[1] = CAST_ZEXT; bus.req_lhs[1] = 32'h22;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("bp%0d_req_ready", c), 32'(bus.req_ready), 32'd0);
         chk($sformatf("bp%0d_rsp_valid", c), 32'(bus.rsp_valid), 32'd1);
         chk($sformatf("bp%0d_rsp_id", c), 32'(bus.rsp_id), 32'd0);
         chk($sformatf("bp%0d_rsp_ret", c), bus.rsp_ret, 32'h11);
         @(posedge clk); #1;
      end
      bus.rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(bus.req_ready), 32'b0010);
      @(posedge clk); #1;
      chk("bp_next_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_next_id", 32'(bus.rsp_id), 32'd1);
      chk("bp_next_ret", bus.rsp_ret, 32'h22);
      bus.req_valid = '0;
      @(posedge clk); #1;
      chk("bp_idle_valid", 32'(bus.rsp_valid), 32'd0);

      // Reset while FULL discards the result; first grant afterwards is index 0
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'b1000; bus.req_opcode[3] = CAST_SEXT; bus.req_lhs[3] = 32'h8000_0000;
      #1;
      chk("rst_pre_ready", 32'(bus.req_ready), 32'b1000);
      @(posedge clk); #1;
      chk("rst_full_id", 32'(bus.rsp_id), 32'd3);
      chk("rst_full_ret", bus.rsp_ret, 32'h8000_0000);
      reset_n = 1'b0;
      bus.rsp_ready = 1'b1;
      bus.req_valid = 4'b1111;
      #1;
      chk("rst_ready_low", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("rst_rsp_ret", bus.rsp_ret, 32'd0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      reset_n = 1'b1;
      #1;
      chk("rst_first_grant", 32'(bus.req_ready), 32'b0001);
      @(posedge clk); #1;
      chk("rst_first_id", 32'(bus.rsp_id), 32'd0);
      reset_n = 1'b0;
      bus.req_valid = '0;
      @(posedge clk); #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
